// File: rtl/avalon_aon_timer.sv
// Always-on machine timer / software-interrupt block on a 32-bit Avalon-MM slave.
// Holds a free-running 64-bit mtime, a 64-bit mtimecmp, the msip bit and an
// enable bit. It drives a level timer interrupt and a level software interrupt.
module avalon_aon_timer #(
  parameter int unsigned PRESCALE = 50,  // clk cycles per mtime increment, 1..65535
  parameter int unsigned AW       = 5    // decoded byte-address width
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          avn_read,
  input  logic          avn_write,
  input  logic [AW-1:0] avn_address,
  input  logic [3:0]    avn_byte_enable,
  input  logic [31:0]   avn_writedata,
  output logic [31:0]   avn_readdata,
  output logic          avn_waitrequest,
  output logic          timer_interrupt,
  output logic          software_interrupt
);

  // Word offsets within the window (byte offset >> 2).
  localparam logic [AW-3:0] W_MSIP   = (AW-2)'(0);
  localparam logic [AW-3:0] W_CMP_LO = (AW-2)'(2);
  localparam logic [AW-3:0] W_CMP_HI = (AW-2)'(3);
  localparam logic [AW-3:0] W_MT_LO  = (AW-2)'(4);
  localparam logic [AW-3:0] W_MT_HI  = (AW-2)'(5);
  localparam logic [AW-3:0] W_CTRL   = (AW-2)'(6);

  localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic          en;
  logic [15:0]   pcnt;
  logic [31:0]   hi_shadow;
  logic          rd_done;

  logic [AW-3:0] word;
  logic          rd_start;
  logic          tick;
  logic [63:0]   mtime_nxt;
  logic [15:0]   pcnt_nxt;
  logic [31:0]   rdata_mux;
  logic          addr_lsb_unused;

  assign word            = avn_address[AW-1:2];
  assign addr_lsb_unused = ^avn_address[1:0];

  // A read captures data in its first cycle; a simultaneous write takes priority.
  assign rd_start        = avn_read & ~avn_write & ~rd_done;
  // Stall is also masked by reset so an in-flight read is dropped at once.
  assign avn_waitrequest = rd_start & ~rst;

  assign software_interrupt = msip;

  // Merge write data into a 32-bit word honouring the byte lanes.
  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Prescaler and mtime next state; a bus write to mtime overrides the tick lane-wise.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    tick      = en && (pcnt == PCNT_LAST);
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    pcnt_nxt  = pcnt;
    if (en) pcnt_nxt = tick ? 16'd0 : pcnt + 16'd1;
    if (avn_write && word == W_MT_LO) begin
      mtime_nxt[31:0] = merge(mtime_nxt[31:0], avn_writedata, avn_byte_enable);
      pcnt_nxt        = 16'd0;
    end
    if (avn_write && word == W_MT_HI) begin
      mtime_nxt[63:32] = merge(mtime_nxt[63:32], avn_writedata, avn_byte_enable);
      pcnt_nxt         = 16'd0;
    end
  end

  // Read-data select; mtime high word comes from the shadow latched by the low read.
  always_comb begin
    rdata_mux = 32'd0;
    case (word)
      W_MSIP:   rdata_mux = {31'd0, msip};
      W_CMP_LO: rdata_mux = mtimecmp[31:0];
      W_CMP_HI: rdata_mux = mtimecmp[63:32];
      W_MT_LO:  rdata_mux = mtime[31:0];
      W_MT_HI:  rdata_mux = hi_shadow;
      W_CTRL:   rdata_mux = {31'd0, en};
      default:  rdata_mux = 32'd0;
    endcase
  end

  // Register state, bus writes, read capture and the registered timer compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every flop here has an explicit reset value; there is no memory array to leave unreset.
      mtime           <= 64'd0;
      mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip            <= 1'b0;
      en              <= 1'b1;
      pcnt            <= 16'd0;
      hi_shadow       <= 32'd0;
      rd_done         <= 1'b0;
      avn_readdata    <= 32'd0;
      timer_interrupt <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      mtime           <= mtime_nxt;
      pcnt            <= pcnt_nxt;
      timer_interrupt <= (mtime >= mtimecmp);
      rd_done         <= rd_start;
      if (avn_write && word == W_CMP_LO)
        mtimecmp[31:0]  <= merge(mtimecmp[31:0], avn_writedata, avn_byte_enable);
      if (avn_write && word == W_CMP_HI)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], avn_writedata, avn_byte_enable);
      if (avn_write && word == W_MSIP && avn_byte_enable[0])
        msip <= avn_writedata[0];
      if (avn_write && word == W_CTRL && avn_byte_enable[0])
        en <= avn_writedata[0];
      if (rd_start) begin
        avn_readdata <= rdata_mux;
        if (word == W_MT_LO) hi_shadow <= mtime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_avalon_aon_timer.sv
// Bench for avalon_aon_timer: two instances (PRESCALE 4 and 1) share one bus
// and are compared each cycle against a per-instance behavioural model.
module tb_avalon_aon_timer;

  localparam int AW = 5;
  localparam int PRESC [2] = '{4, 1};

  logic          clk;
  logic          rst;
  logic          avn_read;
  logic          avn_write;
  logic [AW-1:0] avn_address;
  logic [3:0]    avn_byte_enable;
  logic [31:0]   avn_writedata;
  logic [31:0]   rdata [2];
  logic          wreq  [2];
  logic          ti    [2];
  logic          si    [2];

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state, one slot per instance.
  logic [63:0] m_mtime  [2];
  logic [63:0] m_cmp    [2];
  logic [31:0] m_shadow [2];
  int          m_phase  [2];  // enabled cycles since the last mtime increment/write
  bit          m_msip   [2];
  bit          m_en     [2];
  bit          m_ti     [2];

  avalon_aon_timer #(.PRESCALE(4), .AW(AW)) dut4 (
    .clk(clk), .rst(rst), .avn_read(avn_read), .avn_write(avn_write),
    .avn_address(avn_address), .avn_byte_enable(avn_byte_enable),
    .avn_writedata(avn_writedata), .avn_readdata(rdata[0]),
    .avn_waitrequest(wreq[0]), .timer_interrupt(ti[0]),
    .software_interrupt(si[0]));

  avalon_aon_timer #(.PRESCALE(1), .AW(AW)) dut1 (
    .clk(clk), .rst(rst), .avn_read(avn_read), .avn_write(avn_write),
    .avn_address(avn_address), .avn_byte_enable(avn_byte_enable),
    .avn_writedata(avn_writedata), .avn_readdata(rdata[1]),
    .avn_waitrequest(wreq[1]), .timer_interrupt(ti[1]),
    .software_interrupt(si[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mtime[k]  = 64'd0;
      m_cmp[k]    = 64'hFFFF_FFFF_FFFF_FFFF;
      m_shadow[k] = 32'd0;
      m_phase[k]  = 0;
      m_msip[k]   = 1'b0;
      m_en[k]     = 1'b1;
      m_ti[k]     = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_read(input int k, input logic [AW-1:0] a);
    case (a / 4)
      0:       return {31'd0, m_msip[k]};
      2:       return m_cmp[k][31:0];
      3:       return m_cmp[k][63:32];
      4:       return m_mtime[k][31:0];
      5:       return m_shadow[k];
      6:       return {31'd0, m_en[k]};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the model: mtime advances once per PRESCALE enabled cycles.
  task automatic model_step(input int k, input bit wr, input logic [AW-1:0] a,
                            input logic [3:0] be, input logic [31:0] d);
    bit ti_new;
    ti_new = (m_mtime[k] >= m_cmp[k]);
    if (m_en[k]) begin
      m_phase[k] = m_phase[k] + 1;
      if (m_phase[k] == PRESC[k]) begin
        m_phase[k] = 0;
        m_mtime[k] = m_mtime[k] + 64'd1;
      end
    end
    if (wr) begin
      case (a / 4)
        0: if (be[0]) m_msip[k] = d[0];
        2: m_cmp[k][31:0]  = lanes(m_cmp[k][31:0], d, be);
        3: m_cmp[k][63:32] = lanes(m_cmp[k][63:32], d, be);
        4: begin m_mtime[k][31:0]  = lanes(m_mtime[k][31:0], d, be);  m_phase[k] = 0; end
        5: begin m_mtime[k][63:32] = lanes(m_mtime[k][63:32], d, be); m_phase[k] = 0; end
        6: if (be[0]) m_en[k] = d[0];
        default: ;
      endcase
    end
    m_ti[k] = ti_new;
  endtask

  // Advance one clock with the bus as currently driven, then check interrupts.
  task automatic clock_cycle(input bit wr, input logic [AW-1:0] a,
                             input logic [3:0] be, input logic [31:0] d);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, wr, a, be, d);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("timer_irq[%0d]", k), 64'(ti[k]), 64'(m_ti[k]));
      check($sformatf("sw_irq[%0d]", k), 64'(si[k]), 64'(m_msip[k]));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) clock_cycle(1'b0, '0, 4'd0, 32'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    avn_address = a; avn_byte_enable = be; avn_writedata = d; avn_write = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("wr_wait[%0d]", k), 64'(wreq[k]), 64'd0);
    clock_cycle(1'b1, a, be, d);
    avn_write = 1'b0;
  endtask

  task automatic do_rw(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    avn_address = a; avn_byte_enable = be; avn_writedata = d;
    avn_write = 1'b1; avn_read = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("rw_wait[%0d]", k), 64'(wreq[k]), 64'd0);
    clock_cycle(1'b1, a, be, d);
    avn_write = 1'b0; avn_read = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    logic [31:0] exp [2];
    avn_address = a; avn_read = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_wait1[%0d]", k), 64'(wreq[k]), 64'd1);
      exp[k] = model_read(k, a);
      if (a / 4 == 4) m_shadow[k] = m_mtime[k][63:32];
    end
    clock_cycle(1'b0, a, 4'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rd_wait2[%0d]", k), 64'(wreq[k]), 64'd0);
      check($sformatf("rdata[%0d]@%02h", k, a), 64'(rdata[k]), 64'(exp[k]));
    end
    avn_read = 1'b0;
    clock_cycle(1'b0, a, 4'd0, 32'd0);
  endtask

  initial begin
    rst = 1'b1; avn_read = 1'b0; avn_write = 1'b0;
    avn_address = '0; avn_byte_enable = 4'd0; avn_writedata = 32'd0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rdata[%0d]", k), 64'(rdata[k]), 64'd0);
      check($sformatf("rst_wait[%0d]", k), 64'(wreq[k]), 64'd0);
      check($sformatf("rst_ti[%0d]", k), 64'(ti[k]), 64'd0);
      check($sformatf("rst_si[%0d]", k), 64'(si[k]), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset values of compare and control registers.
    do_read(5'h08); do_read(5'h0C); do_read(5'h18);

    // Free-run, then freeze with en=0.
    idle(40);
    do_read(5'h10);
    do_write(5'h18, 4'hF, 32'd0);
    idle(20);
    do_read(5'h10);
    do_read(5'h18);
    do_write(5'h18, 4'h1, 32'd1);

    // Timer interrupt rise at mtime==5 and fall on compare rewrite.
    do_write(5'h10, 4'hF, 32'd0);
    do_write(5'h14, 4'hF, 32'd0);
    do_write(5'h0C, 4'hF, 32'd0);
    do_write(5'h08, 4'hF, 32'd5);
    idle(30);
    do_write(5'h08, 4'hF, 32'hFFFF_FFFF);
    idle(3);

    // Carry out of the low word and the atomic hi shadow.
    do_write(5'h10, 4'hF, 32'hFFFF_FFFF);
    do_write(5'h14, 4'hF, 32'd0);
    do_read(5'h10); idle(3); do_read(5'h14);
    do_read(5'h10); do_read(5'h14);
    do_write(5'h14, 4'hF, 32'hFFFF_FFFF);
    do_write(5'h10, 4'hF, 32'hFFFF_FFFF);
    idle(6);
    do_read(5'h10); do_read(5'h14);

    // Partial-lane write of mtime low.
    do_write(5'h10, 4'b0100, 32'h00AB_0000);
    do_read(5'h10); do_read(5'h14);

    // msip byte lanes and read+write collision.
    do_write(5'h00, 4'b0000, 32'd1);
    do_write(5'h00, 4'b0001, 32'd1);
    do_read(5'h00);
    do_rw(5'h00, 4'b0001, 32'd0);
    do_read(5'h00);
    do_read(5'h04); do_read(5'h1C);

    // Randomised bus traffic.
    for (int i = 0; i < 150; i++) begin
      logic [AW-1:0] a;
      logic [3:0]    be;
      logic [31:0]   d;
      int            op;
      a  = AW'($urandom_range(0, 31));
      be = 4'($urandom);
      d  = $urandom;
      op = $urandom_range(0, 5);
      if (a / 4 == 6 && $urandom_range(0, 1) == 1) d[0] = 1'b1;
      case (op)
        0:       idle($urandom_range(1, 3));
        1, 2:    do_write(a, be, d);
        3:       do_rw(a, be, d);
        default: do_read(a);
      endcase
    end

    // Reset in the middle of a stalled read.
    avn_address = 5'h08; avn_read = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) check($sformatf("mid_wait[%0d]", k), 64'(wreq[k]), 64'd1);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mid_rst_wait[%0d]", k), 64'(wreq[k]), 64'd0);
      check($sformatf("mid_rst_rdata[%0d]", k), 64'(rdata[k]), 64'd0);
      check($sformatf("mid_rst_ti[%0d]", k), 64'(ti[k]), 64'd0);
      check($sformatf("mid_rst_si[%0d]", k), 64'(si[k]), 64'd0);
    end
    avn_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_read(5'h08); do_read(5'h0C); do_read(5'h18);
    do_read(5'h00); do_read(5'h14); do_read(5'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_aon_timer.md
Name: avalon_aon_timer

Overview:
Always-on timer/software-interrupt block occupying the SoC's AON address window on the Avalon data bus. It is a 32-bit Avalon-MM slave holding a 64-bit free-running mtime, a 64-bit mtimecmp and an msip bit. It drives the core's timer_interrupt and software_interrupt inputs, which are currently tied to 0.

Parameters:
PRESCALE, 50, clk cycles per mtime increment (50 MHz clk gives a 1 MHz mtime); legal range 1..65535
AW, 5, byte-address width decoded by the block

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
avn_read  input  1  Avalon read request
avn_write  input  1  Avalon write request
avn_address  input  AW  byte address (bits [1:0] ignored)
avn_byte_enable  input  4  write byte lanes
avn_writedata  input  32  write data
avn_readdata  output  32  read data, registered
avn_waitrequest  output  1  Avalon stall
timer_interrupt  output  1  machine timer interrupt, level
software_interrupt  output  1  machine software interrupt, level (msip)

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high. All flops clear on rst assertion without waiting for clk.
- Reset values:
  - mtime = 0
  - mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF
  - msip = 0
  - ctrl.en = 1
  - prescale counter = 0
  - hi shadow = 0
  - avn_readdata = 0
  - timer_interrupt = 0
  - software_interrupt = 0
  - avn_waitrequest = 0
- Register map (byte offset; unmapped offsets read 0 and ignore writes):
  - 0x00 MSIP: bit0 = msip, other bits read 0.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI.
  - 0x10 MTIME_LO, 0x14 MTIME_HI.
  - 0x18 CTRL: bit0 = en, other bits read 0.
- Writes: complete in the request cycle with avn_waitrequest=0. Each byte lane is updated only where avn_byte_enable is set.
- Reads: two-cycle handshake.
  - Cycle 1: avn_waitrequest = avn_read & ~rd_done (combinational), so it is 1. Readdata is captured into avn_readdata and rd_done is set.
  - Cycle 2: waitrequest = 0 and readdata is valid. rd_done then clears.
  - Back-to-back reads therefore each take 2 cycles.
  - avn_read and avn_write asserted together: the write is performed, the read is ignored, waitrequest = 0.
- Prescaler: while en=1, the counter counts 0..PRESCALE-1. On terminal count it wraps to 0 and mtime increments by 1 (64-bit, wraps FFFF..FF -> 0).
  - en=0 freezes both the counter and mtime.
  - PRESCALE=1 increments mtime every cycle.
- mtime write vs tick: a write to MTIME_LO/HI in the same cycle as a tick wins for the written lanes. Unwritten lanes take the incremented value. The prescale counter resets to 0 on any mtime write.
- Atomic mtime read:
  - Reading MTIME_LO returns the live low word and, in the same capture cycle, latches mtime[63:32] into the hi shadow.
  - Reading MTIME_HI returns the shadow.
  - Software reads LO then HI.
- Interrupts:
  - timer_interrupt is registered: timer_interrupt <= (mtime >= mtimecmp), using an unsigned 64-bit compare of current register values. It asserts 1 cycle after the condition becomes true and deasserts 1 cycle after a mtimecmp/mtime write makes it false.
  - software_interrupt = msip register (registered, no extra lag).
- Reset mid-read: waitrequest and rd_done clear immediately. The pending read is dropped and the master must reissue it.

Test Plan:
- Reset then read 0x08/0x0C/0x18 -> FFFF_FFFF, FFFF_FFFF, 0000_0001. Each read shows waitrequest=1 for 1 cycle, then readdata on cycle 2. Both interrupts are 0.
- PRESCALE=4, en=1, run 40 cycles, read MTIME_LO -> 10 (±1 depending on read capture cycle). Write CTRL=0, wait 20 cycles -> value unchanged.
- Write MTIMECMP_HI=0, MTIMECMP_LO=5 with PRESCALE=1 -> timer_interrupt rises exactly 1 cycle after mtime reaches 5. Write MTIMECMP_LO=FFFF_FFFF -> deasserts 1 cycle later.
- Write MTIME_LO=FFFF_FFFF, MTIME_HI=0 (PRESCALE=1). Read LO, then HI after further ticks -> HI returns the shadow consistent with the LO read (0 or 1), never a torn value. Write MTIME_HI=FFFF_FFFF, LO=FFFF_FFFF -> wraps to 0.
- Write MSIP with byte_enable=4'b0000 -> msip stays 0. With 4'b0001 and data 1 -> software_interrupt=1 the next cycle. Simultaneous read+write to 0x00 -> write applied, waitrequest=0.
- Assert rst while avn_waitrequest=1 mid-read -> waitrequest drops asynchronously and all registers return to reset values. Reissue the read -> normal 2-cycle completion.
